ysyx_23060201_lsu_sram: RTL
===========================

# ysyx_23060201_lsu_sram

Data-memory responder for the NPC core. It sits on the far side of the execute stage's load/store port and services one request at a time: byte, halfword and word stores with lane masks, and loads with zero or sign extension. It holds a word-organised SRAM array and answers with a fixed, parameterised latency through a valid/ready handshake. Illegal, misaligned or out-of-range accesses produce an error response instead of corrupting memory.

## Interface
- `ADDR_WIDTH`, 32, request address width.
- `DATA_WIDTH`, 32, data width; fixed at 32.
- `DEPTH_WORDS`, 1024, number of 32-bit words in the array.
- `BASE_ADDR`, 32'h8000_0000, byte address of word 0.
- `LATENCY`, 2, cycles from request accept to `resp_valid`; must be ≥ 1.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_wen`  in  1  store request.
- `req_waddr`  in  ADDR_WIDTH  store byte address.
- `req_wmask`  in  8  store size in bits [3:0]: 0001 = byte, 0011 = half, 1111 = word.
- `req_wdata`  in  DATA_WIDTH  store data, right-aligned.
- `req_ren`  in  1  load request.
- `req_raddr`  in  ADDR_WIDTH  load byte address.
- `req_rmask`  in  8  load size in bits [3:0] (same codes as stores); bit 4 = 1 sign-extends, 0 zero-extends.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  requester accepts the response.
- `resp_rdata`  out  DATA_WIDTH  load result, extended to 32 bits; 0 for stores, nops and errors.
- `resp_err`  out  1  request was rejected.

## Operation
- FSM states:
  - IDLE: `req_ready` = 1.
  - WAIT: holds for LATENCY−1 cycles, counted by a down-counter.
  - RESP: `resp_valid` = 1.
- FSM transitions:
  - IDLE → WAIT (or straight to RESP when LATENCY = 1) on `req_valid && req_ready`; all `req_*` fields are latched.
  - WAIT → RESP when the counter reaches 0.
  - RESP → IDLE on `resp_ready`.
- Commit point: the transition into RESP. At that edge the store is written (if legal), and `resp_rdata` and `resp_err` are registered.
- Address check: `off = addr − BASE_ADDR`. The access is out of range if the word index `off[ADDR_WIDTH-1:2]` ≥ DEPTH_WORDS; the subtraction wraps modulo 2^ADDR_WIDTH, so addresses below the base are out of range.
- Error conditions (any one sets `resp_err` = 1, with no write and `resp_rdata` = 0):
  - both `req_wen` and `req_ren` = 1;
  - size code not 0001, 0011 or 1111;
  - halfword with `addr[0]` = 1;
  - word with `addr[1:0]` ≠ 0;
  - out of range.
- Neither `req_wen` nor `req_ren` set: nop; response has err = 0 and rdata = 0.
- Store: byte-lane enables = size code << `addr[1:0]`; data = `req_wdata` << (8·`addr[1:0]`). Only enabled lanes of the target word change.
- Load: `word >> (8·addr[1:0])`, truncated to the size, then extended per `req_rmask[4]`.

## Timing
- Reset values:
  - `req_ready` = 0 while `rst` is high, then 1 (state IDLE).
  - `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 0.
  - WAIT counter = 0.
  - Array contents are not reset.
- Reset mid-operation: a pending request is dropped. A store not yet at its commit edge is never written; a store already committed stays written.
- Latency: request accepted at edge N → `resp_valid` high from edge N+LATENCY.
- Back-to-back: the response handshake at edge M puts the FSM in IDLE after M, so the next accept is at the earliest M+1. Peak throughput is one transaction per LATENCY+1 cycles.
- `resp_rdata` and `resp_err` are stable while `resp_valid && !resp_ready`.
- `req_ready` is 0 in WAIT and RESP; requests offered then are ignored, not latched.
- `req_*` fields are sampled only at the accept edge; later changes have no effect.
- A load immediately following a store to the same word returns the stored data (the store committed in an earlier transaction).

## Test plan
- Word store 0xDEADBEEF at 0x8000_0010, then word load at 0x8000_0010 with rmask 0x1F → rdata 0xDEADBEEF, err 0, `resp_valid` exactly LATENCY cycles after each accept.
- Byte store 0x80 at 0x8000_0013 over word 0x11223344, then:
  - load byte at 0x8000_0013 with rmask 0x11 → 0xFFFF_FF80;
  - with rmask 0x01 → 0x0000_0080;
  - word load → 0x80223344.
- Halfword at 0x8000_0001, word at 0x8000_0002, wmask 0x07, wen = ren = 1, and address 0x7FFF_FFFC → each returns err 1 and rdata 0; the array is unchanged (verified by a subsequent word read).
- `resp_ready` held low for 5 cycles → `resp_valid` and `resp_rdata` stay constant, `req_ready` stays 0, and a request offered meanwhile is not serviced.
- Store accepted, then `rst` pulsed for 1 cycle before the commit edge → no response; a later load of that word returns its pre-store value; all outputs are at reset values during `rst`.
- LATENCY = 1 build: 8 back-to-back loads with `resp_ready` tied to 1 → one response every 2 cycles, all data correct.

Source files
------------

// File: rtl/ysyx_23060201_lsu_sram_if.sv
// ---------------------------------------------------------------------------
// ysyx_23060201_lsu_sram_if
// Load/store request/response bundle between the execute stage (master) and
// the data-memory responder (slave).
//   req_valid/req_ready   : request handshake
//   req_wen/waddr/wmask/wdata : store fields (size code in wmask[3:0])
//   req_ren/raddr/rmask   : load fields (size code in rmask[3:0], rmask[4]
//                           selects sign extension)
//   resp_valid/resp_ready : response handshake
//   resp_rdata/resp_err   : load result and rejection flag
// ---------------------------------------------------------------------------
interface ysyx_23060201_lsu_sram_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wen;
  logic [ADDR_WIDTH-1:0] req_waddr;
  logic [7:0]            req_wmask;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  req_ren;
  logic [ADDR_WIDTH-1:0] req_raddr;
  logic [7:0]            req_rmask;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_wen, req_waddr, req_wmask, req_wdata,
           req_ren, req_raddr, req_rmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_waddr, req_wmask, req_wdata,
           req_ren, req_raddr, req_rmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/ysyx_23060201_lsu_sram.sv
// ---------------------------------------------------------------------------
// ysyx_23060201_lsu_sram
// Data-memory responder: one request at a time, fixed LATENCY from accept to
// the first cycle resp_valid is seen, byte/half/word stores with lane masks,
// zero/sign-extending loads, and an error response for illegal, misaligned
// or out-of-range accesses (which never touch the array).
// Ports:
//   clk : sole clock, rising edge
//   rst : synchronous, active-high reset
//   bus : slave side of ysyx_23060201_lsu_sram_if
// ---------------------------------------------------------------------------
module ysyx_23060201_lsu_sram #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(32'h8000_0000),
  parameter int                    LATENCY     = 2
) (
  input logic                     clk,
  input logic                     rst,
  ysyx_23060201_lsu_sram_if.slave bus
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CNT_W-1:0]      CNT_INIT = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_C  = ADDR_WIDTH'(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  typedef struct packed {
    logic                  wen;
    logic                  ren;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [7:0]            wmask;
    logic [7:0]            rmask;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  req_t                  req_q, req_in, req_cur;
  logic                  req_ready, accept, commit;
  logic [DATA_WIDTH-1:0] resp_rdata_q;
  logic                  resp_err_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

  logic [ADDR_WIDTH-1:0] addr, off;
  logic [3:0]            size, be;
  logic [1:0]            lane;
  logic [IDX_W-1:0]      idx;
  logic                  size_ok, align_ok, range_ok, is_err, do_store, do_load;
  logic [DATA_WIDTH-1:0] wdata_sh, rd_sh, load_data;

  // In IDLE the live bus fields are the request being decoded: with
  // LATENCY = 1 the accept edge is also the commit edge, before req_q holds it.
  always_comb begin
    req_in.wen   = bus.req_wen;
    req_in.ren   = bus.req_ren;
    req_in.waddr = bus.req_waddr;
    req_in.raddr = bus.req_raddr;
    req_in.wmask = bus.req_wmask;
    req_in.rmask = bus.req_rmask;
    req_in.wdata = bus.req_wdata;
    req_cur      = (state_q == S_IDLE) ? req_in : req_q;
  end

  // Request decode and legality checks.
  always_comb begin
    addr     = req_cur.wen ? req_cur.waddr : req_cur.raddr;
    size     = req_cur.wen ? req_cur.wmask[3:0] : req_cur.rmask[3:0];
    lane     = addr[1:0];
    off      = addr - BASE_ADDR;  // wraps, so addresses below the base fail range
    idx      = off[IDX_W+1:2];
    size_ok  = size inside {4'b0001, 4'b0011, 4'b1111};
    align_ok = (size == 4'b0011) ? !addr[0] :
               (size == 4'b1111) ? (lane == 2'b00) : 1'b1;
    range_ok = {2'b00, off[ADDR_WIDTH-1:2]} < DEPTH_C;
    is_err   = (req_cur.wen && req_cur.ren) ||
               ((req_cur.wen || req_cur.ren) && !(size_ok && align_ok && range_ok));
    do_store = req_cur.wen && !is_err;
    do_load  = req_cur.ren && !is_err;
    be       = size << lane;
    wdata_sh = req_cur.wdata << {lane, 3'b000};
    rd_sh    = mem_q[idx] >> {lane, 3'b000};
    case (size)
      4'b0001: load_data = {{24{req_cur.rmask[4] & rd_sh[7]}},  rd_sh[7:0]};
      4'b0011: load_data = {{16{req_cur.rmask[4] & rd_sh[15]}}, rd_sh[15:0]};
      default: load_data = rd_sh;
    endcase
  end

  // Next-state logic.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: if (accept) begin
        state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
        cnt_d   = CNT_INIT;
      end
      S_WAIT: if (cnt_q == '0) state_d = S_RESP;
              else             cnt_d   = cnt_q - 1'b1;
      S_RESP: if (bus.resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Entering RESP is the commit point for the store and the response.
  assign commit = (state_d == S_RESP) && (state_q != S_RESP) && !rst;

  // State register, latched request, registered response.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) req_q <= req_in;
      if (commit) begin
        resp_rdata_q <= do_load ? load_data : '0;
        resp_err_q   <= is_err;
      end
    end
  end

  // NOTE: the array has no reset; clearing a RAM would force flops instead
  // of a macro, and its contents are undefined until written anyway.
  always_ff @(posedge clk) begin
    if (commit && do_store) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  // Outputs; all forced to reset values while rst is high.
  always_comb begin
    req_ready      = (state_q == S_IDLE) && !rst;
    accept         = bus.req_valid && req_ready;
    bus.req_ready  = req_ready;
    bus.resp_valid = (state_q == S_RESP) && !rst;
    bus.resp_rdata = rst ? '0 : resp_rdata_q;
    bus.resp_err   = rst ? 1'b0 : resp_err_q;
  end

endmodule
